prbs31_bert_ctrl: RTL and testbench
===================================

Name: prbs31_bert_ctrl

Overview:
Sequencer for the PRBS31 generator/checker pair. It starts the generator, drives the checker through self-synchronisation (seed load), and confirms lock over a run of error-free bits. It then counts bit errors over a programmable measurement window and reports the result. It sits between the top-level pin/config logic and the PRBS31 datapath, which it controls through enable and seed strobes.

Parameters:
CNT_W, 24, width of the measurement window counter.
ERR_W, 16, width of the error counter (saturating).
SYNC_LEN, 31, number of cycles chk_seed is held to fill the checker shift register.
LOCK_GOOD, 64, consecutive error-free bits required to declare lock.
MAX_RETRY, 3, seed attempts before sync_fail.

Ports:
clk  in  1  clock; all state changes on its rising edge.
rst_n  in  1  reset; asynchronous and active-high (1 = reset).
start  in  1  single-cycle pulse; begins a test from IDLE, DONE or FAIL.
abort  in  1  forces return to IDLE; takes priority over start.
window  in  CNT_W  measurement length in bits, sampled when start is accepted.
err_bit  in  1  checker mismatch for the current bit (1 = error).
gen_en  out  1  generator shift enable.
chk_seed  out  1  checker loads the received bit into its shift register (self-sync).
chk_en  out  1  checker shift/compare enable.
busy  out  1  high in SEED, VERIFY and MEASURE.
locked  out  1  high in MEASURE, and in DONE after a successful run.
done  out  1  high in DONE and FAIL.
sync_fail  out  1  high in FAIL.
err_count  out  ERR_W  errors counted in MEASURE.
err_sat  out  1  err_count has saturated.

Behaviour:
- Reset values: state = IDLE; all outputs 0; internal counters 0; window register 0.
- States: IDLE, SEED, VERIFY, MEASURE, DONE, FAIL (registered Moore outputs).
- IDLE: all enables 0. On start, latch window, clear err_count/err_sat/retry, and enter SEED on the next edge.
- SEED: gen_en = chk_en = chk_seed = 1 for exactly SYNC_LEN cycles. err_bit is ignored. Then enter VERIFY.
- VERIFY: gen_en = chk_en = 1, chk_seed = 0. A good-run counter increments on each err_bit = 0.
  - On err_bit = 1: clear the good-run counter and increment retry.
  - If retry reaches MAX_RETRY, enter FAIL. Otherwise re-enter SEED (full SYNC_LEN again).
  - When the good-run counter reaches LOCK_GOOD: if window = 0, enter DONE with locked = 1; otherwise enter MEASURE.
- MEASURE: gen_en = chk_en = 1. Counts exactly window cycles.
  - err_count increments on each err_bit = 1 and holds at 2^ERR_W-1; err_sat sets on reaching max and is sticky.
  - Lock is not re-evaluated here.
  - After the window-th sampled bit, enter DONE.
- DONE: enables 0; done = 1; locked = 1; err_count held. On start, restart exactly as from IDLE.
- FAIL: enables 0; done = 1; sync_fail = 1; locked = 0; err_count = 0. On start, restart as from IDLE.
- start is ignored in SEED, VERIFY and MEASURE.
- abort in any state: IDLE on the next edge. Enables, locked, done and sync_fail drop that edge; err_count/err_sat retain their value until the next accepted start.
- start and abort in the same cycle: abort wins.
- The window counter must not wrap: a window of 2^CNT_W-1 measures exactly that many bits.
- Asynchronous reset mid-test: immediately return to reset values; no partial result is preserved.
- Latency: start at edge N gives gen_en = 1 from edge N+1. Minimum start-to-done with window = W is SYNC_LEN + LOCK_GOOD + W + 1 cycles.

Test Plan:
- Reset held, then released; start pulsed; err_bit = 0; window = 1000 → chk_seed high for exactly 31 cycles, locked after 64 more cycles, done 1096 cycles after start, err_count = 0.
- Same run, with err_bit = 1 on 5 scattered MEASURE cycles → err_count = 5, err_sat = 0, locked = 1.
- err_bit = 1 on the 10th VERIFY cycle of every attempt → 3 SEED phases observed; then FAIL with sync_fail = 1, done = 1, gen_en = 0.
- ERR_W = 4, err_bit stuck at 1 only during MEASURE, window = 40 → err_count = 15, err_sat = 1, done after 40 measured bits.
- abort asserted mid-MEASURE together with start → IDLE next edge, busy = 0, start ignored, err_count holds its partial value; a later start clears it.
- window = 0 → DONE directly after lock, err_count = 0; a second start from DONE repeats the full sequence.

Source files
------------

// File: rtl/prbs31_bert_ctrl.sv
// prbs31_bert_ctrl: sequencer for the PRBS31 generator/checker pair.
// Starts the generator, self-synchronises the checker by seeding it, confirms
// lock over a run of error-free bits, then counts errors over a window.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active-high (1 = reset)
//   start      single-cycle pulse; begins a test from IDLE, DONE or FAIL
//   abort      returns to IDLE on the next edge; beats start
//   window     measurement length in bits, latched when start is accepted
//   err_bit    checker mismatch for the current bit
//   gen_en     generator shift enable
//   chk_seed   checker loads received bits into its shift register
//   chk_en     checker shift/compare enable
//   busy       test in progress (SEED, VERIFY, MEASURE)
//   locked     lock confirmed (MEASURE, DONE)
//   done       test finished (DONE, FAIL)
//   sync_fail  lock could not be obtained within the retry budget
//   err_count  saturating error count from the measurement window
//   err_sat    err_count has reached its maximum (sticky)
module prbs31_bert_ctrl #(
    parameter int unsigned CNT_W     = 24,
    parameter int unsigned ERR_W     = 16,
    parameter int unsigned SYNC_LEN  = 31,
    parameter int unsigned LOCK_GOOD = 64,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] window,
    input  logic             err_bit,
    output logic             gen_en,
    output logic             chk_seed,
    output logic             chk_en,
    output logic             busy,
    output logic             locked,
    output logic             done,
    output logic             sync_fail,
    output logic [ERR_W-1:0] err_count,
    output logic             err_sat
);

    localparam int unsigned SEED_W  = $clog2(SYNC_LEN + 1);
    localparam int unsigned GOOD_W  = $clog2(LOCK_GOOD + 1);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEED    = 3'd1,
        S_VERIFY  = 3'd2,
        S_MEASURE = 3'd3,
        S_DONE    = 3'd4,
        S_FAIL    = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     win_q, win_d;
    logic [CNT_W-1:0]     meas_q, meas_d;
    logic [SEED_W-1:0]    seed_q, seed_d;
    logic [GOOD_W-1:0]    good_q, good_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic                 sat_q, sat_d;
    logic                 gen_en_q, gen_en_d;
    logic                 chk_seed_q, chk_seed_d;
    logic                 chk_en_q, chk_en_d;
    logic                 busy_q, busy_d;
    logic                 locked_q, locked_d;
    logic                 done_q, done_d;
    logic                 sync_fail_q, sync_fail_d;

    // Next-state, counters and output decode of the next state
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        meas_d      = meas_q;
        seed_d      = seed_q;
        good_d      = good_q;
        retry_d     = retry_q;
        err_d       = err_q;
        sat_d       = sat_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        state_d = S_SEED;
                        win_d   = window;
                        err_d   = '0;
                        sat_d   = 1'b0;
                        retry_d = '0;
                        seed_d  = '0;
                        good_d  = '0;
                    end
                end
                S_SEED: begin
                    if (seed_q == SEED_W'(SYNC_LEN - 1)) begin
                        state_d = S_VERIFY;
                        good_d  = '0;
                    end else begin
                        seed_d = seed_q + SEED_W'(1);
                    end
                end
                S_VERIFY: begin
                    if (err_bit) begin
                        good_d  = '0;
                        retry_d = retry_q + RETRY_W'(1);
                        if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
                            state_d = S_FAIL;
                        end else begin
                            state_d = S_SEED;
                            seed_d  = '0;
                        end
                    end else if (good_q == GOOD_W'(LOCK_GOOD - 1)) begin
                        // Remaining-bits counter is loaded here so a full-scale
                        // window counts down without ever wrapping.
                        if (win_q == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_MEASURE;
                            meas_d  = win_q;
                        end
                    end else begin
                        good_d = good_q + GOOD_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (err_bit && (err_q != ERR_MAX)) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    sat_d = sat_q | (err_d == ERR_MAX);
                    if (meas_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        meas_d = meas_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        gen_en_d    = (state_d == S_SEED) || (state_d == S_VERIFY) || (state_d == S_MEASURE);
        chk_en_d    = gen_en_d;
        busy_d      = gen_en_d;
        chk_seed_d  = (state_d == S_SEED);
        locked_d    = (state_d == S_MEASURE) || (state_d == S_DONE);
        done_d      = (state_d == S_DONE) || (state_d == S_FAIL);
        sync_fail_d = (state_d == S_FAIL);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            win_q       <= '0;
            meas_q      <= '0;
            seed_q      <= '0;
            good_q      <= '0;
            retry_q     <= '0;
            err_q       <= '0;
            sat_q       <= 1'b0;
            gen_en_q    <= 1'b0;
            chk_seed_q  <= 1'b0;
            chk_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
            done_q      <= 1'b0;
            sync_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            meas_q      <= meas_d;
            seed_q      <= seed_d;
            good_q      <= good_d;
            retry_q     <= retry_d;
            err_q       <= err_d;
            sat_q       <= sat_d;
            gen_en_q    <= gen_en_d;
            chk_seed_q  <= chk_seed_d;
            chk_en_q    <= chk_en_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
            done_q      <= done_d;
            sync_fail_q <= sync_fail_d;
        end
    end

    assign gen_en    = gen_en_q;
    assign chk_seed  = chk_seed_q;
    assign chk_en    = chk_en_q;
    assign busy      = busy_q;
    assign locked    = locked_q;
    assign done      = done_q;
    assign sync_fail = sync_fail_q;
    assign err_count = err_q;
    assign err_sat   = sat_q;

endmodule

// File: tb/tb_prbs31_bert_ctrl.sv
// tb_prbs31_bert_ctrl: randomized and directed bench for prbs31_bert_ctrl
// with a phase/count reference model checked every cycle.
module tb_prbs31_bert_ctrl;

    localparam int unsigned CNT_W     = 11;
    localparam int unsigned ERR_W     = 4;
    localparam int unsigned SYNC_LEN  = 31;
    localparam int unsigned LOCK_GOOD = 64;
    localparam int unsigned MAX_RETRY = 3;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    localparam int M_IDLE = 0, M_SEED = 1, M_VERIFY = 2, M_MEASURE = 3, M_DONE = 4, M_FAIL = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] window = '0;
    logic             err_bit = 1'b0;
    logic             gen_en, chk_seed, chk_en, busy, locked, done, sync_fail, err_sat;
    logic [ERR_W-1:0] err_count;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    prbs31_bert_ctrl #(
        .CNT_W(CNT_W), .ERR_W(ERR_W), .SYNC_LEN(SYNC_LEN),
        .LOCK_GOOD(LOCK_GOOD), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst_n(rst), .start(start), .abort(abort), .window(window),
        .err_bit(err_bit), .gen_en(gen_en), .chk_seed(chk_seed), .chk_en(chk_en),
        .busy(busy), .locked(locked), .done(done), .sync_fail(sync_fail),
        .err_count(err_count), .err_sat(err_sat)
    );

    always #5 clk = ~clk;

    // Reference model: phase plus plain integer tallies
    int m_phase = M_IDLE;
    int m_seed_cyc = 0, m_good = 0, m_tries = 0, m_meas = 0, m_win = 0, m_errs = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = M_IDLE; m_seed_cyc = 0; m_good = 0; m_tries = 0;
            m_meas = 0; m_win = 0; m_errs = 0;
        end else if (abort) begin
            m_phase = M_IDLE;
        end else begin
            case (m_phase)
                M_IDLE, M_DONE, M_FAIL: if (start) begin
                    m_win = int'(window); m_errs = 0; m_tries = 0;
                    m_seed_cyc = 0; m_phase = M_SEED;
                end
                M_SEED: begin
                    m_seed_cyc++;
                    if (m_seed_cyc == SYNC_LEN) begin m_phase = M_VERIFY; m_good = 0; end
                end
                M_VERIFY: begin
                    if (err_bit) begin
                        m_good = 0; m_tries++;
                        if (m_tries == MAX_RETRY) m_phase = M_FAIL;
                        else begin m_phase = M_SEED; m_seed_cyc = 0; end
                    end else begin
                        m_good++;
                        if (m_good == LOCK_GOOD) begin
                            if (m_win == 0) m_phase = M_DONE;
                            else begin m_phase = M_MEASURE; m_meas = 0; end
                        end
                    end
                end
                M_MEASURE: begin
                    m_meas++;
                    if (err_bit) m_errs++;
                    if (m_meas == m_win) m_phase = M_DONE;
                end
                default: m_phase = M_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_on) begin
            logic [7:0] act_f, exp_f;
            int exp_err;
            bit run_ph, exp_sat;
            run_ph  = (m_phase == M_SEED) || (m_phase == M_VERIFY) || (m_phase == M_MEASURE);
            exp_err = (m_phase == M_FAIL) ? 0 : ((m_errs > ERR_MAX) ? ERR_MAX : m_errs);
            exp_sat = (m_phase != M_FAIL) && (m_errs >= ERR_MAX);
            exp_f = {run_ph, m_phase == M_SEED, run_ph, run_ph,
                     (m_phase == M_MEASURE) || (m_phase == M_DONE),
                     (m_phase == M_DONE) || (m_phase == M_FAIL),
                     m_phase == M_FAIL, exp_sat};
            act_f = {gen_en, chk_seed, chk_en, busy, locked, done, sync_fail, err_sat};
            vectors++;
            if ((act_f !== exp_f) || (int'(err_count) != exp_err)) begin
                miscompares++;
                $display("FAIL cycle t=%0t flags(gen,seed,chk,busy,lock,done,sfail,sat) got %b want %b err_count got %0d want %0d",
                         $time, act_f, exp_f, err_count, exp_err);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // One test run: pulse start, drive err_bit per mode, stop at done (or abort)
    task automatic run(input int w, input int mode, output int dcyc, output int seed_cyc,
                       output int seed_phases, output int lock_c);
        int  c;
        bit  prev_seed;
        bit  abort_seen;
        @(negedge clk);
        window = CNT_W'(w); start = 1'b1; err_bit = 1'b0;
        c = 0; seed_cyc = 0; seed_phases = 0; lock_c = 0; prev_seed = 1'b0;
        dcyc = -1; abort_seen = 1'b0;
        while (c < 6000) begin
            @(negedge clk);
            c++; start = 1'b0; abort = 1'b0;
            if (chk_seed) seed_cyc++;
            if (chk_seed && !prev_seed) seed_phases++;
            prev_seed = chk_seed;
            if (locked && lock_c == 0) lock_c = c;
            if (done) begin dcyc = c; break; end
            if (abort_seen) break;
            case (mode)
                0: err_bit = 1'b0;
                1: err_bit = (c == 200) || (c == 350) || (c == 500) || (c == 777) || (c == 1000);
                2: err_bit = (m_phase == M_VERIFY) && (m_good == 9);
                3: err_bit = (m_phase == M_MEASURE);
                default: begin
                    err_bit = (m_phase == M_MEASURE) ? ($urandom_range(0, 7) == 0)
                                                     : ($urandom_range(0, 99) == 0);
                    window  = CNT_W'($urandom);
                    start   = ($urandom_range(0, 63) == 0);
                    abort   = ($urandom_range(0, 1499) == 0);
                    abort_seen = abort;
                end
            endcase
        end
        err_bit = 1'b0; start = 1'b0; abort = 1'b0;
        if (dcyc < 0 && !abort_seen) begin
            vectors++; miscompares++;
            $display("FAIL run_timeout: got no done after %0d cycles want done", c);
        end
    endtask

    initial begin
        int d, sc, sp, lc;

        // Reset
        repeat (3) @(negedge clk);
        check("reset_flags", int'({gen_en, chk_seed, chk_en, busy, locked, done, sync_fail, err_sat}), 0);
        check("reset_err_count", int'(err_count), 0);
        rst = 1'b0;
        chk_on = 1'b1;

        // Clean run, window 1000
        run(1000, 0, d, sc, sp, lc);
        check("clean_done_cycle", d, 1096);
        check("clean_seed_cycles", sc, 31);
        check("clean_lock_cycle", lc, 96);
        check("clean_err_count", int'(err_count), 0);

        // Five scattered measurement errors
        run(1000, 1, d, sc, sp, lc);
        check("five_err_count", int'(err_count), 5);
        check("five_err_sat", int'(err_sat), 0);
        check("five_locked", int'(locked), 1);
        check("five_done_cycle", d, 1096);

        // Error on 10th verify bit of each attempt -> FAIL
        run(1000, 2, d, sc, sp, lc);
        check("fail_seed_phases", sp, 3);
        check("fail_done_cycle", d, 124);
        check("fail_sync_fail", int'(sync_fail), 1);
        check("fail_done", int'(done), 1);
        check("fail_gen_en", int'(gen_en), 0);
        check("fail_locked", int'(locked), 0);

        // Saturation with err_bit stuck during measurement
        run(40, 3, d, sc, sp, lc);
        check("sat_err_count", int'(err_count), 15);
        check("sat_err_sat", int'(err_sat), 1);
        check("sat_done_cycle", d, 136);

        // Abort together with start mid-measurement
        @(negedge clk);
        window = CNT_W'(1000); start = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            start = 1'b0;
            err_bit = (c == 150) || (c == 170) || (c == 190);
        end
        abort = 1'b1; start = 1'b1; err_bit = 1'b0;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_gen_en", int'(gen_en), 0);
        check("abort_locked", int'(locked), 0);
        check("abort_err_hold", int'(err_count), 3);
        repeat (5) @(negedge clk);
        check("abort_idle_busy", int'(busy), 0);
        check("abort_idle_err", int'(err_count), 3);
        window = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_err_clear", int'(err_count), 0);
        check("restart_busy", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // Window 0, twice back to back
        run(0, 0, d, sc, sp, lc);
        check("w0_done_cycle", d, 96);
        check("w0_locked", int'(locked), 1);
        check("w0_err_count", int'(err_count), 0);
        run(0, 0, d, sc, sp, lc);
        check("w0_again_done_cycle", d, 96);
        check("w0_again_seed_cycles", sc, 31);

        // Full-scale window must not wrap
        run(2047, 0, d, sc, sp, lc);
        check("wmax_done_cycle", d, 96 + 2047);

        // Asynchronous reset mid-measurement
        @(negedge clk);
        window = CNT_W'(500); start = 1'b1;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            start = 1'b0;
            err_bit = (c == 100) || (c == 101);
        end
        err_bit = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("areset_flags", int'({gen_en, chk_seed, chk_en, busy, locked, done, sync_fail, err_sat}), 0);
        check("areset_err", int'(err_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Randomized runs
        for (int i = 0; i < 15; i++) begin
            run(int'($urandom_range(1, 300)), 4, d, sc, sp, lc);
            repeat (int'($urandom_range(1, 4))) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
